alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: req0 is the EX-stage issue path, req1 is the multi-cycle helper unit.
- Round-robin arbitration with one transaction in flight at a time.
- Operands and config are registered, then driven to the ALU. The ALU result is captured and returned on a per-requester valid/ready response channel.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding, ALU config codes and width defaults for alu_arbiter
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CONF_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] CONF_AND = 4'b0000;
    localparam logic [3:0] CONF_OR  = 4'b0001;
    localparam logic [3:0] CONF_ADD = 4'b0010;
    localparam logic [3:0] CONF_SUB = 4'b0011;
    localparam logic [3:0] CONF_SLT = 4'b0100;
    localparam logic [3:0] CONF_NOR = 4'b0101;
    localparam logic [3:0] CONF_XOR = 4'b0110;
    localparam logic [3:0] CONF_SLL = 4'b0111;
    localparam logic [3:0] CONF_SRL = 4'b1000;
    localparam logic [3:0] CONF_SRA = 4'b1001;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; combinational, last grant held by the parent
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        grant_o  = 2'b00;
        if (valid_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = valid_i[1];
        end
        if (|valid_i) begin
            grant_o = {winner_o, ~winner_o};
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters; ALU_ARB_PERF_EN adds stall counters
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CONF_W = CONF_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [CONF_W-1:0] i_req0_conf,
    input  logic              i_req0_sign,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [CONF_W-1:0] i_req1_conf,
    input  logic              i_req1_sign,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_result,
    input  logic              i_rsp0_ready,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_result,
    input  logic              i_rsp1_ready,
    output logic [CONF_W-1:0] o_alu_conf,
    output logic              o_alu_sign,
    output logic [DATA_W-1:0] o_alu_data_1,
    output logic [DATA_W-1:0] o_alu_data_2,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [15:0]       o_perf_wait0,
    output logic [15:0]       o_perf_wait1
);

    state_e              state_q, state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic [CONF_W-1:0]   conf_q;
    logic                sign_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result_q;
    logic [1:0]          grant;
    logic                winner;
    logic                accept;
    logic                owner_rsp_ready;

    rr_arb2 u_arb (
        .valid_i      ({i_req1_valid, i_req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .winner_o     (winner)
    );

    // Ready is offered only in IDLE, so a grant there is always an accepted transaction.
    assign accept          = (state_q == ST_IDLE) && (|grant);
    assign o_req0_ready    = accept & grant[0];
    assign o_req1_ready    = accept & grant[1];
    assign owner_rsp_ready = owner_q ? i_rsp1_ready : i_rsp0_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (owner_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            conf_q       <= '0;
            sign_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= winner;
                last_grant_q <= winner;
                conf_q       <= winner ? i_req1_conf : i_req0_conf;
                sign_q       <= winner ? i_req1_sign : i_req0_sign;
                a_q          <= winner ? i_req1_a    : i_req0_a;
                b_q          <= winner ? i_req1_b    : i_req0_b;
            end
            if (state_q == ST_EXEC) begin
                result_q <= i_alu_result;
            end
        end
    end

    assign o_alu_conf    = conf_q;
    assign o_alu_sign    = sign_q;
    assign o_alu_data_1  = a_q;
    assign o_alu_data_2  = b_q;
    assign o_rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign o_rsp1_valid  = (state_q == ST_RESP) && owner_q;
    assign o_rsp0_result = result_q;
    assign o_rsp1_result = result_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] wait0_q, wait1_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            if (i_req0_valid && !o_req0_ready && (wait0_q != 16'hFFFF)) wait0_q <= wait0_q + 16'd1;
            if (i_req1_valid && !o_req1_ready && (wait1_q != 16'hFFFF)) wait1_q <= wait1_q + 16'd1;
        end
    end

    assign o_perf_wait0 = wait0_q;
    assign o_perf_wait1 = wait1_q;
`else
    assign o_perf_wait0 = 16'd0;
    assign o_perf_wait1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an ALU stub and a transaction-level model
module tb_alu_arbiter;
    import alu_arb_pkg::*;

`ifdef ALU_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req0_valid = 0, i_req1_valid = 0;
    logic        o_req0_ready, o_req1_ready;
    logic [3:0]  i_req0_conf = 0, i_req1_conf = 0;
    logic        i_req0_sign = 0, i_req1_sign = 0;
    logic [31:0] i_req0_a = 0, i_req0_b = 0, i_req1_a = 0, i_req1_b = 0;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic [31:0] o_rsp0_result, o_rsp1_result;
    logic        i_rsp0_ready = 1, i_rsp1_ready = 1;
    logic [3:0]  o_alu_conf;
    logic        o_alu_sign;
    logic [31:0] o_alu_data_1, o_alu_data_2, i_alu_result;
    logic [15:0] o_perf_wait0, o_perf_wait1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_conf(i_req0_conf),
        .i_req0_sign(i_req0_sign), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_conf(i_req1_conf),
        .i_req1_sign(i_req1_sign), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .o_rsp0_valid(o_rsp0_valid), .o_rsp0_result(o_rsp0_result), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp1_valid(o_rsp1_valid), .o_rsp1_result(o_rsp1_result), .i_rsp1_ready(i_rsp1_ready),
        .o_alu_conf(o_alu_conf), .o_alu_sign(o_alu_sign),
        .o_alu_data_1(o_alu_data_1), .o_alu_data_2(o_alu_data_2), .i_alu_result(i_alu_result),
        .o_perf_wait0(o_perf_wait0), .o_perf_wait1(o_perf_wait1)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            CONF_AND: r = a & b;
            CONF_OR:  r = a | b;
            CONF_ADD: r = a + b;
            CONF_SUB: r = a - b;
            CONF_SLT: r = s ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
            CONF_NOR: r = ~(a | b);
            CONF_XOR: r = a ^ b;
            CONF_SLL: r = b << a[4:0];
            CONF_SRL: r = b >> a[4:0];
            CONF_SRA: r = $unsigned($signed(b) >>> a[4:0]);
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    // The ALU stub responds to whatever the arbiter drives onto the ALU port.
    always_comb i_alu_result = alu_ref(o_alu_conf, o_alu_sign, o_alu_data_1, o_alu_data_2);

    int checks = 0, passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { int own; logic [31:0] res; } exp_t;
    exp_t sb[$];

    // Transaction-level model, advanced once per cycle by the monitor.
    bit          busy = 0, just_rst = 0;
    int          own = 0, last = 1, cyc = 0, acc_cyc = 0;
    int          pw0 = 0, pw1 = 0;
    int          acc_cnt[2] = '{0, 0};
    logic [3:0]  x_conf;
    logic        x_sign;
    logic [31:0] x_a, x_b;
    bit          e0, e1, rv0, rv1;
    int          who;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (i_rst) begin
                busy = 0; sb.delete(); last = 1; pw0 = 0; pw1 = 0; just_rst = 1;
            end else begin
                if (just_rst) begin
                    check("rst_alu_conf", o_alu_conf, 0);
                    check("rst_alu_sign", o_alu_sign, 0);
                    check("rst_alu_d1", o_alu_data_1, 0);
                    check("rst_alu_d2", o_alu_data_2, 0);
                    check("rst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 0);
                    check("rst_rsp_result", {o_rsp1_result, o_rsp0_result}, 0);
                    just_rst = 0;
                end
                check("perf_wait0", o_perf_wait0, PERF ? pw0 : 0);
                check("perf_wait1", o_perf_wait1, PERF ? pw1 : 0);
                e0 = !busy && i_req0_valid && (!i_req1_valid || last == 1);
                e1 = !busy && i_req1_valid && !e0;
                check("req0_ready", o_req0_ready, e0);
                check("req1_ready", o_req1_ready, e1);
                if (i_req0_valid && !e0 && pw0 < 65535) pw0++;
                if (i_req1_valid && !e1 && pw1 < 65535) pw1++;
                if (busy && (cyc - acc_cyc) == 1) begin
                    check("exec_alu_conf", o_alu_conf, x_conf);
                    check("exec_alu_sign", o_alu_sign, x_sign);
                    check("exec_alu_d1", o_alu_data_1, x_a);
                    check("exec_alu_d2", o_alu_data_2, x_b);
                end
                rv0 = busy && own == 0 && (cyc - acc_cyc) >= 2;
                rv1 = busy && own == 1 && (cyc - acc_cyc) >= 2;
                check("rsp0_valid", o_rsp0_valid, rv0);
                check("rsp1_valid", o_rsp1_valid, rv1);
                if (o_rsp0_valid || o_rsp1_valid) begin
                    who = o_rsp1_valid ? 1 : 0;
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        check("rsp_owner", who, sb[0].own);
                        check("rsp_result", who ? o_rsp1_result : o_rsp0_result, sb[0].res);
                        if (who ? i_rsp1_ready : i_rsp0_ready) void'(sb.pop_front());
                    end
                end
                if ((rv0 && i_rsp0_ready) || (rv1 && i_rsp1_ready)) busy = 0;
                if (e0 || e1) begin
                    own = e1 ? 1 : 0;
                    busy = 1; last = own; acc_cyc = cyc;
                    x_conf = e1 ? i_req1_conf : i_req0_conf;
                    x_sign = e1 ? i_req1_sign : i_req0_sign;
                    x_a    = e1 ? i_req1_a    : i_req0_a;
                    x_b    = e1 ? i_req1_b    : i_req0_b;
                    sb.push_back('{own: own, res: alu_ref(x_conf, x_sign, x_a, x_b)});
                    acc_cnt[own]++;
                end
            end
        end
    end

    // Stimulus side: holds requests until the model reports acceptance.
    bit rand_mode = 0;
    int hold0 = 0, hold1 = 0;
    int seen[2] = '{0, 0};

    task automatic set_req(input int n, input logic [3:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            i_req0_conf = c; i_req0_sign = s; i_req0_a = a; i_req0_b = b; i_req0_valid = 1;
        end else begin
            i_req1_conf = c; i_req1_sign = s; i_req1_a = a; i_req1_b = b; i_req1_valid = 1;
        end
    endtask

    task automatic rand_req(input int n);
        set_req(n, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (acc_cnt[0] != seen[0]) begin seen[0] = acc_cnt[0]; i_req0_valid = 0; end
        if (acc_cnt[1] != seen[1]) begin seen[1] = acc_cnt[1]; i_req1_valid = 0; end
        if (hold0 > 0) begin hold0--; i_rsp0_ready = 0; end
        else i_rsp0_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (hold1 > 0) begin hold1--; i_rsp1_ready = 0; end
        else i_rsp1_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rand_mode) begin
            if (!i_req0_valid) begin if ($urandom_range(0, 2) == 0) rand_req(0); end
            else if ($urandom_range(0, 15) == 0) i_req0_valid = 0;
            if (!i_req1_valid) begin if ($urandom_range(0, 2) == 0) rand_req(1); end
            else if ($urandom_range(0, 15) == 0) i_req1_valid = 0;
        end
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while ((n == 0 ? i_req0_valid : i_req1_valid) && k < 60) begin
            tick();
            k++;
        end
        check(n == 0 ? "accept0_timeout" : "accept1_timeout", n == 0 ? i_req0_valid : i_req1_valid, 0);
    endtask

    task automatic settle;
        repeat (5) tick();
    endtask

    initial begin
        tick(); tick();
        i_rst = 0;

        set_req(0, CONF_SUB, 0, 32'd10, 32'd3);
        set_req(1, CONF_XOR, 0, 32'hFF, 32'h0F);
        wait_acc(1);
        check("perf_wait1_tie", o_perf_wait1, PERF ? 16'd3 : 16'd0);
        settle();

        set_req(0, CONF_ADD, 0, 32'd5, 32'd7);
        wait_acc(0);
        settle();

        set_req(0, CONF_AND, 0, 32'hF0F0, 32'hFF00);
        set_req(1, CONF_OR, 0, 32'h1, 32'h2);
        wait_acc(1);
        settle();

        set_req(0, CONF_SLT, 1, 32'hFFFF_FFFF, 32'd1);
        hold0 = 8;
        wait_acc(0);
        set_req(1, CONF_NOR, 0, 32'h0, 32'h0);
        wait_acc(1);
        settle();

        set_req(0, 4'b1111, 0, 32'd1, 32'd2);
        wait_acc(0);
        settle();

        set_req(1, CONF_SLL, 0, 32'd4, 32'd1);
        wait_acc(1);
        i_rst = 1;
        tick();
        i_rst = 0;
        set_req(1, CONF_SLL, 0, 32'd4, 32'd1);
        wait_acc(1);
        settle();

        rand_mode = 1;
        repeat (800) tick();
        rand_mode = 0;
        i_req0_valid = 0;
        i_req1_valid = 0;
        repeat (8) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
